// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with sticky error flags.
// Supports registered-read and first-word-fall-through modes.
module param_sync_fifo #(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 64,
    parameter  int AF_LEVEL = DEPTH - 4,
    parameter  int AE_LEVEL = 4,
    parameter  int FWFT     = 0,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_full;
    logic             r_empty;
    logic             r_af;
    logic             r_ae;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Advance a pointer, wrapping at the last entry for any depth.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == P_LAST) ? '0 : p + 1'b1;
    endfunction

    // Acceptance is gated by the registered flags only.
    always_comb begin
        w_wr_acc     = wr_en & ~r_full;
        w_rd_acc     = rd_en & ~r_empty;
        w_wr_ptr_nxt = w_wr_acc ? f_inc(r_wr_ptr) : r_wr_ptr;
        w_rd_ptr_nxt = w_rd_acc ? f_inc(r_rd_ptr) : r_rd_ptr;
    end

    // Next occupancy: up on write only, down on read only.
    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_cnt_nxt = r_count + CW'(1);
            2'b01:   w_cnt_nxt = r_count - CW'(1);
            default: w_cnt_nxt = r_count;
        endcase
    end

    // Pointers, count and status flags, all from next-state count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= (AF_LEVEL <= 0);
            r_ae     <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == C_DEPTH);
            r_empty  <= (w_cnt_nxt == '0);
            r_af     <= (int'(w_cnt_nxt) >= AF_LEVEL);
            r_ae     <= (int'(w_cnt_nxt) <= AE_LEVEL);
        end
    end

    // Storage array; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Sticky error flags; a new error wins over a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (wr_en && r_full) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
            if (rd_en && r_empty) begin
                r_unf <= 1'b1;
            end else if (clr_err) begin
                r_unf <= 1'b0;
            end
        end
    end

    if (FWFT == 0) begin : g_std

        // Registered read: word appears the cycle after the pop.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_rd_data <= '0;
            end else if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end

    end else begin : g_fwft

        logic [PW-1:0] w_head_ptr;
        logic          w_bypass;

        // Head after this edge; bypass when it is the word being written.
        always_comb begin
            w_head_ptr = w_rd_ptr_nxt;
            w_bypass   = w_wr_acc && (r_wr_ptr == w_head_ptr);
        end

        // Preload the head word so it is visible whenever not empty.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_rd_data <= '0;
            end else if (w_wr_acc || w_rd_acc) begin
                r_rd_data <= w_bypass ? wr_data : r_mem[w_head_ptr];
            end
        end

    end

    assign rd_data      = r_rd_data;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: DEPTH=6 in both read modes,
// driven in lockstep against a queue scoreboard.
module tb_param_sync_fifo;

    localparam int W  = 8;
    localparam int D  = 6;
    localparam int AF = 4;
    localparam int AE = 1;

    logic         clk;
    logic         rst_n;
    logic         wr_en;
    logic         rd_en;
    logic         clr_err;
    logic [W-1:0] wr_data;

    logic [W-1:0] rd0, rd1;
    logic [2:0]   cnt0, cnt1;
    logic         full0, full1, emp0, emp1;
    logic         af0, af1, ae0, ae1;
    logic         ov0, ov1, un0, un1;

    int n_checks = 0;
    int n_err    = 0;

    logic [W-1:0] sb [$];

    typedef struct {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        int         cnt;
        logic       ov;
        logic       un;
        string      tag;
    } vec_t;

    vec_t tbl [$];

    param_sync_fifo #(
        .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF),
        .AE_LEVEL(AE), .FWFT(0)
    ) u_std (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd0),
        .full(full0), .empty(emp0),
        .almost_full(af0), .almost_empty(ae0),
        .count(cnt0),
        .overflow(ov0), .underflow(un0),
        .clr_err(clr_err)
    );

    param_sync_fifo #(
        .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF),
        .AE_LEVEL(AE), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd1),
        .full(full1), .empty(emp1),
        .almost_full(af1), .almost_empty(ae1),
        .count(cnt1),
        .overflow(ov1), .underflow(un1),
        .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    // One clock: drive inputs, check the FWFT head before the
    // edge, update the scoreboard, then check both DUTs after it.
    task automatic step(input logic wr, input logic rd,
                        input logic clr, input logic rst,
                        input logic [7:0] din, input int ec,
                        input logic eov, input logic eun,
                        input string tag);
        logic       wa, ra;
        logic [7:0] popped;
        wr_en   = wr;
        rd_en   = rd;
        clr_err = clr;
        rst_n   = ~rst;
        wr_data = din;
        #1;
        if (!rst && sb.size() > 0)
            chk({tag, "/fwft_head"}, 32'(rd1), 32'(sb[0]));
        wa     = !rst && wr && (sb.size() < D);
        ra     = !rst && rd && (sb.size() > 0);
        popped = 8'h00;
        if (ra) popped = sb[0];
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
        end else begin
            if (ra) void'(sb.pop_front());
            if (wa) sb.push_back(din);
        end
        chk({tag, "/count0"}, 32'(cnt0), 32'(ec));
        chk({tag, "/count1"}, 32'(cnt1), 32'(ec));
        chk({tag, "/full0"}, 32'(full0), 32'(ec == D));
        chk({tag, "/full1"}, 32'(full1), 32'(ec == D));
        chk({tag, "/empty0"}, 32'(emp0), 32'(ec == 0));
        chk({tag, "/empty1"}, 32'(emp1), 32'(ec == 0));
        chk({tag, "/af0"}, 32'(af0), 32'(ec >= AF));
        chk({tag, "/af1"}, 32'(af1), 32'(ec >= AF));
        chk({tag, "/ae0"}, 32'(ae0), 32'(ec <= AE));
        chk({tag, "/ae1"}, 32'(ae1), 32'(ec <= AE));
        chk({tag, "/ovf0"}, 32'(ov0), 32'(eov));
        chk({tag, "/ovf1"}, 32'(ov1), 32'(eov));
        chk({tag, "/unf0"}, 32'(un0), 32'(eun));
        chk({tag, "/unf1"}, 32'(un1), 32'(eun));
        if (ra)
            chk({tag, "/std_rdata"}, 32'(rd0), 32'(popped));
        if (rst)
            chk({tag, "/std_rdata_rst"}, 32'(rd0), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        wr_data = '0;

        for (int i = 0; i < 6; i++)
            tbl.push_back('{1'b1, 1'b0, 1'b0, 8'(8'h10 + i),
                            i + 1, 1'b0, 1'b0, "fill"});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h99, 6,
                        1'b1, 1'b0, "ovf_wr"});
        for (int i = 0; i < 6; i++)
            tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 5 - i,
                            1'b1, 1'b0, "drain"});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 0,
                        1'b1, 1'b1, "unf_rd"});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h20, 1,
                        1'b1, 1'b1, "wr_rd_empty"});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 1,
                        1'b0, 1'b0, "clr_idle"});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b1, 1'b0, 1'b0, 8'(8'h21 + i),
                            2 + i, 1'b0, 1'b0, "refill"});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h26, 5,
                        1'b1, 1'b0, "wr_rd_full"});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h27, 6,
                        1'b1, 1'b0, "top_up"});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h28, 6,
                        1'b1, 1'b0, "clr_vs_ovf"});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 6,
                        1'b0, 1'b0, "clr_after"});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 5 - i,
                            1'b0, 1'b0, "to_three"});

        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0,
             1'b0, 1'b0, "reset0");
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 0,
             1'b0, 1'b0, "reset1");

        foreach (tbl[i])
            step(tbl[i].wr, tbl[i].rd, tbl[i].clr, 1'b0,
                 tbl[i].din, tbl[i].cnt, tbl[i].ov,
                 tbl[i].un, tbl[i].tag);

        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h30 + i), 3,
                 1'b0, 1'b0, "stream");

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h50, 4,
             1'b0, 1'b0, "to_four");
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 0,
             1'b0, 1'b0, "rst_mid");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hAB, 1,
             1'b0, 1'b0, "post_wr");
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0,
             1'b0, 1'b0, "post_rd");
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0,
             1'b0, 1'b0, "idle");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, >= 1.
REQ-002 Parameter DEPTH, default 64: storage entries, >= 2; need not be a power of two.
REQ-003 Parameter AF_LEVEL, default DEPTH-4: almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 4: almost_empty asserts when count <= AE_LEVEL.
REQ-005 Parameter FWFT, default 0: 0 = standard registered-read mode; 1 = first-word-fall-through mode.
REQ-006 Derived CW = $clog2(DEPTH+1), the count width.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 wr_en  in  1  write request.
REQ-010 wr_data  in  WIDTH  write data.
REQ-011 rd_en  in  1  read (pop) request.
REQ-012 rd_data  out  WIDTH  read data.
REQ-013 full  out  1  count == DEPTH.
REQ-014 empty  out  1  no word available for reading.
REQ-015 almost_full  out  1  count >= AF_LEVEL.
REQ-016 almost_empty  out  1  count <= AE_LEVEL.
REQ-017 count  out  CW  words currently stored.
REQ-018 overflow  out  1  sticky: a write was attempted while full.
REQ-019 underflow  out  1  sticky: a read was attempted while empty.
REQ-020 clr_err  in  1  clears overflow and underflow.

Function
REQ-021 A write is accepted iff wr_en=1 and full=0; wr_data is stored at wr_ptr, and wr_ptr advances.
REQ-022 A read is accepted iff rd_en=1 and empty=0; rd_ptr advances.
REQ-023 Both pointers wrap from DEPTH-1 to 0 for any DEPTH.
REQ-024 Full and empty gating uses the current registered flags, so a read in the same cycle does not unblock a write when full.
REQ-025 When empty, a simultaneous write is accepted and the read is rejected.
REQ-026 Count changes as follows: +1 on a write only, -1 on a read only, unchanged on both or neither; it never exceeds DEPTH and never goes below 0.
REQ-027 full, empty, almost_full, almost_empty and count are registered and are derived from the next-state count, so they are valid in the cycle after the edge.
REQ-028 With FWFT=0, rd_data is registered and updates to mem[rd_ptr] one cycle after an accepted read; otherwise it holds its value.
REQ-029 With FWFT=0, empty is (count == 0).
REQ-030 With FWFT=1, rd_data presents the head word whenever empty=0, without requiring rd_en; an accepted read pops that word, and the next word (if any) appears on the following cycle.
REQ-031 With FWFT=1, empty=0 the cycle after the first write into an empty FIFO, and rd_data is valid in that same cycle.
REQ-032 With FWFT=1 and empty=1, the value of rd_data is don't-care.
REQ-033 overflow is set on wr_en=1 while full=1, and underflow is set on rd_en=1 while empty=1.
REQ-034 clr_err clears both sticky flags; a set event in the same cycle takes priority over the clear.
REQ-035 Rejected requests do not change pointers, count, memory or rd_data.
REQ-036 Storage is inferable as a single-port-write, single-port-read RAM, and the memory array is not reset.

Reset
REQ-037 While rst_n=0 at an edge, the following SHALL hold next cycle: rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), rd_data=0, overflow=0, underflow=0.
REQ-038 Reset asserted mid-operation discards all contents, and wr_en/rd_en are ignored on that edge.

Verification
REQ-039 Bench SHALL cover each scenario below with WIDTH=8, DEPTH=6, AF_LEVEL=4, AE_LEVEL=1, in both FWFT=0 and FWFT=1.
REQ-040 Fill with 0x10..0x15 -> count reaches 6, full=1, and almost_full=1 from count 4; a 7th write sets overflow, count stays 6, and contents are unchanged.
REQ-041 Drain all 6 entries -> rd_data sequence is 0x10..0x15 in order, with FWFT=0 lagging one cycle; a 7th read sets underflow, and empty=1.
REQ-042 Push and pop continuously for 20 cycles starting at count 3 -> count holds 3, data order is preserved across pointer wrap, and no error flags are set.
REQ-043 Simultaneous write and read when full -> read accepted, write rejected, count 5, overflow=1; when empty -> write accepted, count 1, underflow=1.
REQ-044 Assert rst_n=0 for 1 cycle at count 4 -> all REQ-037 values hold, and a subsequent write of 0xAB then read returns 0xAB.
REQ-045 Assert clr_err with no error event -> both flags clear; assert clr_err together with wr_en while full -> overflow remains 1.
